// File: rtl/axi_sram_slave.sv
// AXI3 slave terminating a CPU-side master on a word-addressed on-chip SRAM.
// Independent read and write FSMs, INCR bursts, programmable read latency.
module axi_sram_slave #(
  parameter int MEM_AW   = 12,
  parameter int RD_DELAY = 1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        wlast_err
);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  localparam logic [3:0] DELAY_M1 = (RD_DELAY == 0) ? 4'd0 : 4'(RD_DELAY - 1);

  logic [31:0] mem [0:(2**MEM_AW)-1];

  r_state_t            r_state, r_state_d;
  logic [MEM_AW-1:0]   rd_idx, rd_idx_d;
  logic [7:0]          rd_len, rd_len_d, rd_beat, rd_beat_d;
  logic [3:0]          rd_cnt, rd_cnt_d, rid_d;
  logic                arready_d, rvalid_d, rlast_d;
  logic [31:0]         rdata_d;

  w_state_t            w_state, w_state_d;
  logic [MEM_AW-1:0]   wr_idx, wr_idx_d;
  logic [7:0]          wr_len, wr_len_d, wr_beat, wr_beat_d;
  logic [3:0]          bid_d;
  logic                awready_d, wready_d, bvalid_d, wlast_err_d;
  logic                wr_fire;

  logic [MEM_AW-1:0]   ar_idx, aw_idx;
  logic                unused_ok;

  // Byte address to word index; upper and sub-word bits alias.
  assign ar_idx  = araddr[MEM_AW+1:2];
  assign aw_idx  = awaddr[MEM_AW+1:2];
  assign rresp   = 2'b00;
  assign bresp   = 2'b00;
  assign wr_fire = (w_state == W_DATA) && wvalid && wready;
  assign unused_ok = ^{arsize, arburst, arlock, arcache, arprot, awsize, awburst,
                       awlock, awcache, awprot, wid, araddr[31:MEM_AW+2], araddr[1:0],
                       awaddr[31:MEM_AW+2], awaddr[1:0]};

  // Read channel: each beat's data is fetched when the beat is loaded, so
  // a write in that same cycle is not seen but later beats pick it up.
  always_comb begin
    r_state_d = r_state;
    rd_idx_d  = rd_idx;
    rd_len_d  = rd_len;
    rd_beat_d = rd_beat;
    rd_cnt_d  = rd_cnt;
    arready_d = arready;
    rvalid_d  = rvalid;
    rlast_d   = rlast;
    rid_d     = rid;
    rdata_d   = rdata;
    case (r_state)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arready && arvalid) begin
          arready_d = 1'b0;
          rid_d     = arid;
          rd_idx_d  = ar_idx;
          rd_len_d  = arlen;
          rd_beat_d = 8'd0;
          rdata_d   = mem[ar_idx];
          rlast_d   = (arlen == 8'd0);
          if (RD_DELAY == 0) begin
            r_state_d = R_DATA;
            rvalid_d  = 1'b1;
          end else begin
            r_state_d = R_WAIT;
            rd_cnt_d  = DELAY_M1;
          end
        end
      end
      R_WAIT: begin
        if (rd_cnt == 4'd0) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
        end else begin
          rd_cnt_d = rd_cnt - 4'd1;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rlast) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            rd_idx_d  = rd_idx + MEM_AW'(1);
            rdata_d   = mem[rd_idx + MEM_AW'(1)];
            rd_beat_d = rd_beat + 8'd1;
            rlast_d   = ((rd_beat + 8'd1) == rd_len);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      rd_idx  <= '0;
      rd_len  <= '0;
      rd_beat <= '0;
      rd_cnt  <= '0;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
    end else begin
      r_state <= r_state_d;
      rd_idx  <= rd_idx_d;
      rd_len  <= rd_len_d;
      rd_beat <= rd_beat_d;
      rd_cnt  <= rd_cnt_d;
      arready <= arready_d;
      rvalid  <= rvalid_d;
      rlast   <= rlast_d;
      rid     <= rid_d;
      rdata   <= rdata_d;
    end
  end

  // Write channel: the beat counter, not wlast, decides when the burst ends.
  always_comb begin
    w_state_d   = w_state;
    wr_idx_d    = wr_idx;
    wr_len_d    = wr_len;
    wr_beat_d   = wr_beat;
    awready_d   = awready;
    wready_d    = wready;
    bvalid_d    = bvalid;
    bid_d       = bid;
    wlast_err_d = wlast_err;
    case (w_state)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awready && awvalid) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          bid_d     = awid;
          wr_idx_d  = aw_idx;
          wr_len_d  = awlen;
          wr_beat_d = 8'd0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wr_fire) begin
          wr_idx_d  = wr_idx + MEM_AW'(1);
          wr_beat_d = wr_beat + 8'd1;
          if (wlast != (wr_beat == wr_len)) wlast_err_d = 1'b1;
          if (wr_beat == wr_len) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state   <= W_IDLE;
      wr_idx    <= '0;
      wr_len    <= '0;
      wr_beat   <= '0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      wlast_err <= 1'b0;
    end else begin
      w_state   <= w_state_d;
      wr_idx    <= wr_idx_d;
      wr_len    <= wr_len_d;
      wr_beat   <= wr_beat_d;
      awready   <= awready_d;
      wready    <= wready_d;
      bvalid    <= bvalid_d;
      bid       <= bid_d;
      wlast_err <= wlast_err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge aclk) begin
    if (!areset && wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: directed AXI transactions push expected
// R beats and B responses; a negedge monitor pops and compares on handshakes.
module tb_axi_sram_slave;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  arid, rid, awid, wid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready, wlast_err;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  rbeat_t     exp_r[$];
  logic [3:0] exp_b[$];
  int asserts  = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axi_sram_slave #(.MEM_AW(12), .RD_DELAY(1)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready), .wlast_err(wlast_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 1 after the rising edge; main-thread sampling is 1 after the falling edge.
  task automatic drv();
    @(posedge aclk); #1;
  endtask

  task automatic smp();
    @(negedge aclk); #1;
  endtask

  // Monitor: compares every completed R and B handshake against the scoreboard.
  always @(negedge aclk) begin
    if (!areset) begin
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          asserts++; failures++;
          $display("[TB] FAIL r_unexpected: got beat 0x%08h, expected no beat", rdata);
        end else begin
          rbeat_t e;
          e = exp_r.pop_front();
          checkOutput("rdata", rdata, e.data);
          checkOutput("rlast", {31'd0, rlast}, {31'd0, e.last});
          checkOutput("rid", {28'd0, rid}, {28'd0, e.id});
          checkOutput("rresp", {30'd0, rresp}, 32'd0);
        end
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          asserts++; failures++;
          $display("[TB] FAIL b_unexpected: got bid %0d, expected no response", bid);
        end else begin
          checkOutput("bid", {28'd0, bid}, {28'd0, exp_b.pop_front()});
          checkOutput("bresp", {30'd0, bresp}, 32'd0);
        end
      end
    end
  end

  task automatic issueRead(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [127:0] d);
    int n;
    rbeat_t e;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = d[32*i +: 32];
      e.last = (i == int'(len));
      e.id   = id;
      exp_r.push_back(e);
    end
    drv();
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len;
    n = 0;
    smp();
    while (!arready && n < 20) begin smp(); n++; end
    checkOutput("ar_accept", {31'd0, arready}, 32'd1);
    drv();
    arvalid = 1'b0;
  endtask

  task automatic finishRead();
    int n;
    n = 0;
    while (exp_r.size() != 0 && n < 60) begin smp(); n++; end
    checkOutput("r_drain", exp_r.size(), 32'd0);
    smp();
    checkOutput("arready_after_r", {31'd0, arready}, 32'd1);
  endtask

  task automatic doRead(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [127:0] d, input bit chkLat);
    issueRead(id, addr, len, d);
    if (chkLat) begin
      smp();
      checkOutput("rvalid_wait", {31'd0, rvalid}, 32'd0);
      smp();
      checkOutput("rvalid_first", {31'd0, rvalid}, 32'd1);
    end
    finishRead();
  endtask

  task automatic doWrite(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [127:0] d, input logic [3:0] strb, input int lastAt,
                         input bit stallB);
    int n;
    exp_b.push_back(id);
    drv();
    bready = !stallB;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len;
    wvalid = 1'b1; wdata = d[31:0]; wstrb = strb; wlast = (lastAt == 0);
    smp();
    checkOutput("wready_before_aw", {31'd0, wready}, 32'd0);
    n = 0;
    while (!awready && n < 20) begin smp(); n++; end
    checkOutput("aw_accept", {31'd0, awready}, 32'd1);
    drv();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = d[32*i +: 32]; wstrb = strb; wlast = (i == lastAt);
      n = 0;
      smp();
      while (!wready && n < 20) begin smp(); n++; end
      checkOutput("w_accept", {31'd0, wready}, 32'd1);
      drv();
    end
    wvalid = 1'b0; wlast = 1'b0;
    smp();
    checkOutput("bvalid_latency", {31'd0, bvalid}, 32'd1);
    if (stallB) begin
      for (int i = 0; i < 5; i++) begin
        checkOutput("bvalid_held", {31'd0, bvalid}, 32'd1);
        checkOutput("awready_during_b", {31'd0, awready}, 32'd0);
        smp();
      end
      drv();
      bready = 1'b1;
    end
    n = 0;
    while (exp_b.size() != 0 && n < 20) begin smp(); n++; end
    checkOutput("b_drain", exp_b.size(), 32'd0);
    smp();
    checkOutput("awready_after_b", {31'd0, awready}, 32'd1);
  endtask

  task automatic applyStimulus();
    // Reset values and the first cycle of arready/awready afterwards.
    repeat (3) drv();
    smp();
    checkOutput("rst_arready", {31'd0, arready}, 32'd0);
    checkOutput("rst_awready", {31'd0, awready}, 32'd0);
    checkOutput("rst_wready", {31'd0, wready}, 32'd0);
    checkOutput("rst_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("rst_rlast", {31'd0, rlast}, 32'd0);
    checkOutput("rst_bvalid", {31'd0, bvalid}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_ids", {24'd0, rid, bid}, 32'd0);
    checkOutput("rst_wlast_err", {31'd0, wlast_err}, 32'd0);
    drv();
    areset = 1'b0;
    smp();
    checkOutput("arready_released_0", {31'd0, arready}, 32'd0);
    smp();
    checkOutput("arready_released_1", {31'd0, arready}, 32'd1);
    checkOutput("awready_released_1", {31'd0, awready}, 32'd1);

    // Single word write then single read with latency check.
    doWrite(4'd3, 32'h1C00_0010, 8'd0, {96'd0, 32'hDEADBEEF}, 4'hF, 0, 1'b0);
    doRead(4'd5, 32'h1C00_0010, 8'd0, {96'd0, 32'hDEADBEEF}, 1'b1);

    // Four-beat burst write and read back.
    doWrite(4'd1, 32'h0000_0100, 8'd3, {32'h44, 32'h33, 32'h22, 32'h11}, 4'hF, 3, 1'b0);
    checkOutput("wlast_err_clean", {31'd0, wlast_err}, 32'd0);
    doRead(4'd2, 32'h0000_0100, 8'd3, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1);

    // Byte strobe merge.
    doWrite(4'd6, 32'h0000_0200, 8'd0, {96'd0, 32'hAABBCCDD}, 4'hF, 0, 1'b0);
    doWrite(4'd6, 32'h0000_0200, 8'd0, {96'd0, 32'h000000EE}, 4'h1, 0, 1'b0);
    doRead(4'd6, 32'h0000_0200, 8'd0, {96'd0, 32'hAABBCCEE}, 1'b0);

    // rready 1-0-0-1 stall during a four-beat burst.
    rready = 1'b0;
    issueRead(4'd7, 32'h0000_0100, 8'd3, {32'h44, 32'h33, 32'h22, 32'h11});
    drv(); rready = 1'b1;
    drv(); rready = 1'b0;
    smp();
    checkOutput("stall_rdata_a", rdata, 32'h22);
    checkOutput("stall_rvalid_a", {31'd0, rvalid}, 32'd1);
    checkOutput("stall_rlast_a", {31'd0, rlast}, 32'd0);
    drv();
    smp();
    checkOutput("stall_rdata_b", rdata, 32'h22);
    checkOutput("stall_rvalid_b", {31'd0, rvalid}, 32'd1);
    drv(); rready = 1'b1;
    finishRead();

    // bready held low: bvalid held and no new AW accepted.
    doWrite(4'd9, 32'h0000_0300, 8'd0, {96'd0, 32'h12345678}, 4'hF, 0, 1'b1);

    // Early wlast: sticky error, all four beats still written, one B response.
    doWrite(4'd4, 32'h0000_0400, 8'd3, {32'hD0, 32'hC0, 32'hB0, 32'hA0}, 4'hF, 1, 1'b0);
    checkOutput("wlast_err_set", {31'd0, wlast_err}, 32'd1);
    doWrite(4'd4, 32'h0000_0500, 8'd0, {96'd0, 32'h55}, 4'hF, 0, 1'b0);
    checkOutput("wlast_err_sticky", {31'd0, wlast_err}, 32'd1);
    doRead(4'd4, 32'h0000_0400, 8'd3, {32'hD0, 32'hC0, 32'hB0, 32'hA0}, 1'b0);

    // Reset while beat 2 of a burst is presented.
    issueRead(4'd6, 32'h0000_0100, 8'd3, {32'h44, 32'h33, 32'h22, 32'h11});
    drv();
    drv();
    drv();
    rready = 1'b0; areset = 1'b1;
    smp();
    checkOutput("abort_beats_done", exp_r.size(), 32'd2);
    checkOutput("abort_beat2_data", rdata, 32'h33);
    drv();
    areset = 1'b0; rready = 1'b1;
    smp();
    checkOutput("abort_rvalid", {31'd0, rvalid}, 32'd0);
    checkOutput("abort_arready_0", {31'd0, arready}, 32'd0);
    checkOutput("abort_wlast_err", {31'd0, wlast_err}, 32'd0);
    exp_r.delete();
    smp();
    checkOutput("abort_arready_1", {31'd0, arready}, 32'd1);
    doRead(4'd8, 32'h0000_0200, 8'd0, {96'd0, 32'hAABBCCEE}, 1'b1);

    checkOutput("r_queue_empty", exp_r.size(), 32'd0);
    checkOutput("b_queue_empty", exp_b.size(), 32'd0);
  endtask

  initial begin
    areset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01;
    arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01;
    awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3 slave responder that terminates the CPU-side AXI master (instruction/data cache bridge) on a word-addressed on-chip memory. It serves single and INCR burst reads (cache line refills, `arlen`=3) and single or burst writes (uncached stores, dirty-line writebacks) with programmable read latency. It sits on the simulation/SoC side of the CPU's AXI port, directly or behind an interconnect.

## Interface
Parameters:
- MEM_AW, 12, memory word-address width (2^MEM_AW 32-bit words)
- RD_DELAY, 1, wait cycles between AR handshake and first `rvalid` (0..15)

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- arid  in  4  read ID
- araddr  in  32  read byte address
- arlen  in  8  beats minus 1
- arsize  in  3  ignored; full word always returned
- arburst  in  2  ignored; always treated as INCR
- arlock/arcache/arprot  in  2/4/3  ignored
- arvalid  in  1  read address valid
- arready  out  1  read address accepted
- rid  out  4  equals latched `arid`
- rdata  out  32  read data
- rresp  out  2  constant 0 (OKAY)
- rlast  out  1  final beat
- rvalid  out  1  read data valid
- rready  in  1  master accepts beat
- awid  in  4  write ID
- awaddr  in  32  write byte address
- awlen  in  8  beats minus 1
- awsize/awburst/awlock/awcache/awprot  in  3/2/2/4/3  ignored (INCR)
- awvalid  in  1  write address valid
- awready  out  1  write address accepted
- wid  in  4  ignored
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wlast  in  1  checked against beat count
- wvalid  in  1  write data valid
- wready  out  1  write data accepted
- bid  out  4  equals latched `awid`
- bresp  out  2  constant 0
- bvalid  out  1  write response valid
- bready  in  1  master accepts response
- wlast_err  out  1  sticky: `wlast` disagreed with `awlen` count

## Operation
- Word index = addr[MEM_AW+1:2]; addr[1:0] and upper bits ignored (aliasing). Burst address += 4 per beat, wrapping modulo memory size. Memory not reset.
- Read FSM: R_IDLE → R_WAIT → R_DATA → R_IDLE.
  - R_IDLE: `arready`=1. On `arvalid`: latch id, word index, len; load `rdata`←mem[index]; beat counter←0; go R_WAIT (or R_DATA if RD_DELAY=0).
  - R_WAIT: down-counter, RD_DELAY cycles, outputs held.
  - R_DATA: `rvalid`=1, `rlast`=(beat==len). On `rready`: if last → R_IDLE; else index+1, `rdata`←mem[index+1], beat+1, `rvalid` stays 1.
  - `rdata`/`rlast`/`rid` stable while `rvalid && !rready`.
- Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE, independent of read FSM.
  - W_IDLE: `awready`=1, `wready`=0. On `awvalid`: latch id, index, len, beat←0.
  - W_DATA: `wready`=1. On `wvalid`: bytes with `wstrb` set written to mem[index]; index+1, beat+1. If `wlast` ≠ (beat==len), set `wlast_err`. Beat count is authoritative: on beat==len go W_RESP.
  - W_RESP: `bvalid`=1; on `bready` → W_IDLE.
- Simultaneous read load and write to the same word in one cycle: read gets old data. Writes landing on a burst's later words before those beats are loaded are visible; earlier-loaded words are not.

## Timing
- Reset (areset high at edge): all FSMs to IDLE, counters 0, `arready`=`awready`=`wready`=`rvalid`=`rlast`=`bvalid`=0, `rid`=`bid`=0, `rdata`=0, `wlast_err`=0. All outputs registered; `arready`/`awready` first 1 in the cycle after reset is released. Reset mid-burst aborts silently, no response.
- AR handshake at cycle T → first `rvalid` at T+1+RD_DELAY; then one beat per cycle under continuous `rready`; `arready` returns 1 the cycle after the last R handshake.
- Last W handshake at T → `bvalid` at T+1; data readable by an AR accepted at T+1 or later.
- `wready` never asserted before AW accepted; W beats arriving first wait.
- One outstanding read and one outstanding write; no ID reordering.

## Test plan
- Write single word 0x1C00_0010 data 0xDEADBEEF `wstrb`=0xF, then read `arlen`=0, RD_DELAY=1 → `bvalid` one cycle after W; `rvalid` at T+2 with 0xDEADBEEF, `rlast`=1, `rid`=arid.
- Write burst `awlen`=3 from 0x100 with 0x11,0x22,0x33,0x44 (`wlast` on beat 3), read burst `arlen`=3 → four beats 0x11..0x44 back-to-back, `rlast` only on fourth, `wlast_err`=0.
- Byte strobe: word 0x200=0xAABBCCDD, write 0x000000EE `wstrb`=0x1 → read 0xAABBCCEE.
- `rready` toggled 1-0-0-1 during 4-beat burst → `rdata` held while stalled, no beat lost or duplicated; `bready` held low 5 cycles → `bvalid` held, `awready`=0 throughout.
- `wlast`=1 on beat 1 of `awlen`=3 → `wlast_err`=1 and sticky, 4 beats still accepted, single B response.
- Assert areset during R_DATA beat 2 → next cycle `rvalid`=0, `arready`=0, cycle after `arready`=1; new read completes normally.
